pulse_train_sequencer: RTL and testbench
========================================

Name: pulse_train_sequencer

Overview:
Sequences a train of output pulses from a single start request. Each request sets the pulse count, the high time and the low time between pulses. It sits beside the edge-to-pulse generators and drives one-shot or strobe consumers that need N evenly spaced pulses instead of one. Requests arrive on a valid/ready handshake, and completion is reported with a one-cycle done flag.

Parameters:
COUNT_WIDTH, 8, width of pulse_count and pulses_remaining; maximum of 2^COUNT_WIDTH-1 pulses per train.
LENGTH_WIDTH, 8, width of high_length and low_length; maximum of 2^LENGTH_WIDTH-1 cycles per phase.

Ports:
clock  in  1  single clock; all logic is on the rising edge.
clear  in  1  synchronous, active-high reset; priority over every other input.
clock_enable  in  1  when low, freezes all state and blocks the handshake.
start_valid  in  1  request to start a train.
start_ready  out  1  sequencer can accept a request.
pulse_count  in  COUNT_WIDTH  number of pulses; sampled at accept.
high_length  in  LENGTH_WIDTH  cycles high per pulse; sampled at accept.
low_length  in  LENGTH_WIDTH  cycles low between pulses; sampled at accept.
pulse_out  out  1  registered pulse train output.
busy  out  1  a train is in progress (HIGH or LOW state).
done  out  1  one-cycle completion flag.
pulses_remaining  out  COUNT_WIDTH  pulses not yet completed in the current train.

Behaviour:
- Reset (clear=1 at an edge) sets the next cycle to: state IDLE, pulse_out=0, busy=0, done=0, pulses_remaining=0, and all internal counters and latched config to 0.
- States:
  - IDLE: pulse_out=0, busy=0.
  - HIGH: pulse_out=1, busy=1.
  - LOW: pulse_out=0, busy=1.
- start_ready = (state==IDLE) && clock_enable && !clear; it is combinational from registered state.
- Accept happens when start_valid && start_ready. At the accept edge:
  - pulse_count, high_length and low_length are latched; these inputs are ignored afterwards until the next accept.
  - pulses_remaining is loaded with pulse_count.
- A high_length or low_length of 0 is treated as 1. Every phase lasts at least one cycle.
- Transitions when clock_enable=1:
  - IDLE, accept, count>0 -> HIGH. pulse_out is high in the first cycle after the accept edge; latency is 1 cycle.
  - IDLE, accept, count==0 -> IDLE. done=1 in the next cycle and pulse_out never rises.
  - HIGH lasts exactly H cycles. On its last cycle pulses_remaining decrements.
    - If the decremented value is >0: -> LOW.
    - Otherwise: -> IDLE with done=1 in that first IDLE cycle.
  - LOW lasts exactly L cycles, then -> HIGH.
  - There is no trailing low phase after the last pulse.
- done is high for exactly one enabled cycle, then clears. It is not set by a clear-aborted train.
- A new accept is allowed in the done cycle. The next train's first HIGH cycle then directly follows the done cycle, so back-to-back trains have a 1-cycle gap.
- clock_enable=0:
  - All registers hold, including the phase counter and pulses_remaining.
  - pulse_out, busy and done keep their values (a done cycle stretches until the next enabled edge).
  - No accept is possible.
  - After re-enable, the remaining cycles of the current phase complete as if no stall occurred.
- A clear during HIGH or LOW aborts the train immediately. The next cycle is IDLE with pulse_out=0 and done=0.
- clear together with start_valid: the request is not accepted.
- Phase counters are LENGTH_WIDTH wide and never wrap. At all-ones, the phase lasts 2^LENGTH_WIDTH-1 cycles.

Test Plan:
- Basic train: count=3, H=2, L=1, accept in cycle 0. Expect pulse_out=1 in cycles 1-2, 4-5 and 7-8, and 0 in cycles 3 and 6; busy=1 in cycles 1-8; done=1 only in cycle 9; pulses_remaining 3→2 at the end of cycle 2, →1 at the end of cycle 5, →0 at the end of cycle 8.
- Degenerate config: count=0 accepted in cycle 0 gives done=1 in cycle 1, pulse_out and busy stay 0. Separately, count=2, H=0, L=0 gives pulse_out 1,0,1 in cycles 1-3 and done in cycle 4.
- Stall: basic train with clock_enable=0 in cycles 4-6. The pulse_out=1 seen in cycle 4 holds through cycle 7, the remaining schedule shifts by 3 cycles, and done=1 in cycle 12. start_valid asserted while stalled in IDLE is not accepted.
- Abort: basic train with clear=1 in cycle 5. In cycle 6: pulse_out=0, busy=0, start_ready=1, pulses_remaining=0, and done never asserts.
- Back-to-back: start_valid held with count=1, H=1. The first accept is in cycle 0, giving pulse_out in cycle 1 and done plus the second accept in cycle 2. Expect pulse_out=1 in cycle 3 and done again in cycle 4.
- Maximums: count=255, H=255, L=255. Expect exactly 255 pulses, each exactly 255 cycles high, with 254 low gaps of 255 cycles, and done exactly once.

Source files
------------

// File: rtl/pulse_train_sequencer.sv
// Pulse train sequencer: one accepted request produces pulse_count pulses of
// high_length cycles separated by low_length cycles, then a one-cycle done flag.
module pulse_train_sequencer #(
  parameter int unsigned COUNT_WIDTH  = 8,
  parameter int unsigned LENGTH_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    clock_enable,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [COUNT_WIDTH-1:0]  pulse_count,
  input  logic [LENGTH_WIDTH-1:0] high_length,
  input  logic [LENGTH_WIDTH-1:0] low_length,
  output logic                    pulse_out,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  pulses_remaining
);

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  localparam logic [LENGTH_WIDTH-1:0] LenOne   = LENGTH_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]  CountOne = COUNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [LENGTH_WIDTH-1:0] phase_q, phase_d;
  logic [LENGTH_WIDTH-1:0] high_len_q, high_len_d;
  logic [LENGTH_WIDTH-1:0] low_len_q, low_len_d;
  logic [COUNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic                    pulse_q, pulse_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept;

  assign start_ready      = (state_q == StIdle) && clock_enable && !clear;
  assign accept           = start_valid && start_ready;
  assign pulse_out        = pulse_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pulses_remaining = remaining_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    high_len_d  = high_len_q;
    low_len_d   = low_len_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Zero-length phases are stretched to one cycle at latch time.
          high_len_d  = (high_length == '0) ? LenOne : high_length;
          low_len_d   = (low_length == '0) ? LenOne : low_length;
          remaining_d = pulse_count;
          if (pulse_count != '0) begin
            state_d = StHigh;
            phase_d = LenOne;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StHigh: begin
        if (phase_q == high_len_q) begin
          remaining_d = remaining_q - CountOne;
          if (remaining_q != CountOne) begin
            state_d = StLow;
            phase_d = LenOne;
          end else begin
            state_d = StIdle;
            phase_d = '0;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + LenOne;
        end
      end
      StLow: begin
        if (phase_q == low_len_q) begin
          state_d = StHigh;
          phase_d = LenOne;
        end else begin
          phase_d = phase_q + LenOne;
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase

    pulse_d = (state_d == StHigh);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      high_len_q  <= '0;
      low_len_q   <= '0;
      remaining_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (clock_enable) begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      high_len_q  <= high_len_d;
      low_len_q   <= low_len_d;
      remaining_q <= remaining_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Scoreboard bench for pulse_train_sequencer: per-cycle expected outputs are
// queued when a request is driven and popped one per clock after each edge.
module tb_pulse_train_sequencer;

  logic       clock = 1'b0;
  logic       clear;
  logic       clock_enable;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] pulse_count;
  logic [7:0] high_length;
  logic [7:0] low_length;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic [7:0] pulses_remaining;

  pulse_train_sequencer #(
    .COUNT_WIDTH (8),
    .LENGTH_WIDTH(8)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .clock_enable    (clock_enable),
    .start_valid     (start_valid),
    .start_ready     (start_ready),
    .pulse_count     (pulse_count),
    .high_length     (high_length),
    .low_length      (low_length),
    .pulse_out       (pulse_out),
    .busy            (busy),
    .done            (done),
    .pulses_remaining(pulses_remaining)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pulse;
    logic       busy;
    logic       done;
    logic       ready;
    logic [7:0] rem;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_cycle = 0;
  int   cfg_cnt, cfg_high, cfg_low;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cur_cycle, got, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic b, input logic d, input logic r,
                          input int rem);
    exp_t e;
    e.pulse = p;
    e.busy  = b;
    e.done  = d;
    e.ready = r;
    e.rem   = 8'(rem);
    exp_q.push_back(e);
  endtask

  // Expected schedule of one undisturbed train, starting the cycle after accept.
  task automatic push_train(input int cnt, input int h, input int l);
    int he = (h == 0) ? 1 : h;
    int le = (l == 0) ? 1 : l;
    for (int p = 1; p <= cnt; p++) begin
      for (int i = 0; i < he; i++) push_exp(1'b1, 1'b1, 1'b0, 1'b0, cnt - p + 1);
      if (p < cnt) for (int i = 0; i < le; i++) push_exp(1'b0, 1'b1, 1'b0, 1'b0, cnt - p);
    end
    push_exp(1'b0, 1'b0, 1'b1, 1'b1, 0);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_exp(1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic set_cfg(input int c, input int h, input int l);
    cfg_cnt  = c;
    cfg_high = h;
    cfg_low  = l;
  endtask

  task automatic drive(input int c, input int valid_until, input int stall_lo,
                       input int stall_hi, input int clear_at);
    start_valid  = (c < valid_until);
    clock_enable = !(c >= stall_lo && c <= stall_hi);
    clear        = (c == clear_at);
    if (c < valid_until) begin
      pulse_count = 8'(cfg_cnt);
      high_length = 8'(cfg_high);
      low_length  = 8'(cfg_low);
    end else begin
      // Scramble config after accept to prove it was latched.
      pulse_count = 8'($urandom);
      high_length = 8'($urandom);
      low_length  = 8'($urandom);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    e = exp_q.pop_front();
    check_eq("pulse_out", 32'(pulse_out), 32'(e.pulse));
    check_eq("busy", 32'(busy), 32'(e.busy));
    check_eq("done", 32'(done), 32'(e.done));
    check_eq("start_ready", 32'(start_ready), 32'(e.ready));
    check_eq("pulses_remaining", 32'(pulses_remaining), 32'(e.rem));
  endtask

  // Cycle 0 holds the request; every queued entry is one later cycle.
  task automatic run(input int valid_until, input int stall_lo, input int stall_hi,
                     input int clear_at);
    int c = 0;
    drive(0, valid_until, stall_lo, stall_hi, clear_at);
    while (exp_q.size() > 0) begin
      @(posedge clock);
      #1;
      c++;
      cur_cycle = c;
      drive(c, valid_until, stall_lo, stall_hi, clear_at);
      #1;
      compare_front();
    end
    start_valid  = 1'b0;
    clear        = 1'b0;
    clock_enable = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t tmp;
    clear        = 1'b1;
    clock_enable = 1'b1;
    start_valid  = 1'b1;
    pulse_count  = 8'd5;
    high_length  = 8'd1;
    low_length   = 8'd1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_pulse_out", 32'(pulse_out), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_remaining", 32'(pulses_remaining), 32'd0);
    check_eq("ready_during_clear", 32'(start_ready), 32'd0);
    clear       = 1'b0;
    start_valid = 1'b0;
    #1;
    check_eq("ready_after_clear", 32'(start_ready), 32'd1);

    // Basic train.
    set_cfg(3, 2, 1);
    push_train(3, 2, 1);
    push_idle(2);
    run(1, 0, -1, -1);

    // Zero-count request: immediate done, no pulse.
    set_cfg(0, 5, 5);
    push_train(0, 5, 5);
    push_idle(2);
    run(1, 0, -1, -1);

    // Zero lengths behave as one.
    set_cfg(2, 0, 0);
    push_train(2, 0, 0);
    push_idle(2);
    run(1, 0, -1, -1);

    // Stall in cycles 4-6: cycle 4 outputs repeat three more times.
    set_cfg(3, 2, 1);
    push_train(3, 2, 1);
    tmp = exp_q[3];
    for (int i = 0; i < 3; i++) exp_q.insert(4, tmp);
    push_idle(2);
    run(1, 4, 6, -1);

    // Request while stalled in IDLE is refused.
    set_cfg(1, 1, 1);
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_idle(3);
    run(3, 0, 2, -1);

    // Abort with clear in cycle 5.
    set_cfg(3, 2, 1);
    push_train(3, 2, 1);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    push_idle(4);
    run(1, 0, -1, 5);

    // Clear coincident with a request.
    set_cfg(1, 1, 1);
    push_idle(3);
    run(1, 0, -1, 0);

    // Back-to-back: second accept lands in the first done cycle.
    set_cfg(1, 1, 0);
    push_train(1, 1, 0);
    push_train(1, 1, 0);
    push_idle(2);
    run(3, 0, -1, -1);

    // Maximum phase lengths.
    set_cfg(3, 255, 255);
    push_train(3, 255, 255);
    push_idle(2);
    run(1, 0, -1, -1);

    // Maximum pulse count.
    set_cfg(255, 1, 1);
    push_train(255, 1, 1);
    push_idle(2);
    run(1, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
